// File: rtl/snn_buf_pkg.sv
// Shared types and helpers for the spiking-network data buffer arbitration logic.
// Holds the arbiter state type and the round-robin selection function.
package snn_buf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DATA_WIDTH = 32;
  localparam int MAX_REQ    = 8;
  localparam int PTR_W      = 3;

  // First valid index at or after ptr, wrapping at num_req; 0 when nothing is valid.
  function automatic logic [PTR_W-1:0] rr_select(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int unsigned        num_req);
    logic        found;
    int unsigned k;
    rr_select = 3'd0;
    found     = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      k = 32'(ptr) + i;
      if (k >= num_req) begin
        k = k - num_req;
      end else begin
        k = k;
      end
      if ((i < num_req) && !found && valid[k[PTR_W-1:0]]) begin
        rr_select = k[PTR_W-1:0];
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

endpackage

// File: rtl/buffer_write_arbiter_if.sv
// Producer handshakes, buffer write port and arbiter status, bundled as one bus.
// The arbiter uses the slave view; the producer/buffer side uses the master view.
interface buffer_write_arbiter_if
  import snn_buf_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = snn_buf_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          buf_full;
  logic                          buf_write_enable;
  logic [DATA_WIDTH-1:0]         buf_write_data;
  logic                          grant_valid;
  logic [IDX_W-1:0]              grant_id;
  logic [CNT_WIDTH-1:0]          words_written;

  modport master (
    output req_valid, req_last, req_data, buf_full,
    input  req_ready, buf_write_enable, buf_write_data, grant_valid, grant_id, words_written
  );

  modport slave (
    input  req_valid, req_last, req_data, buf_full,
    output req_ready, buf_write_enable, buf_write_data, grant_valid, grant_id, words_written
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: winner index and one-hot for a valid vector and pointer.
// Shared between the write arbiter and the read-side scheduler.
module rr_priority_picker
  import snn_buf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant_onehot,
  output logic [IDX_W-1:0]   o_grant_idx
);
  logic [MAX_REQ-1:0] w_valid_ext;
  logic [PTR_W-1:0]   w_ptr_ext;
  logic [PTR_W-1:0]   w_sel;

  // Widen inputs to the fixed width the selection function works on.
  always_comb begin
    w_valid_ext              = '0;
    w_valid_ext[NUM_REQ-1:0] = i_valid;
    w_ptr_ext                = '0;
    w_ptr_ext[IDX_W-1:0]     = i_ptr;
  end

  assign w_sel          = rr_select(w_valid_ext, w_ptr_ext, NUM_REQ);
  assign o_grant_idx    = w_sel[IDX_W-1:0];
  assign o_grant_onehot = (NUM_REQ'(1) << w_sel) & {NUM_REQ{|i_valid}};
endmodule

// File: rtl/buffer_write_arbiter.sv
// Round-robin arbiter sharing one data-buffer write port among NUM_REQ producers.
// Bursts of up to BURST_LEN words per grant, one idle bubble between grants.
module buffer_write_arbiter
  import snn_buf_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = snn_buf_pkg::DATA_WIDTH,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  buffer_write_arbiter_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  arb_state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_grant_id, w_grant_nxt;
  logic [IDX_W-1:0]      r_rr_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]      w_pick_idx, w_grant_inc;
  logic [BEAT_W-1:0]     r_beat_cnt, w_beat_nxt;
  logic [CNT_WIDTH-1:0]  r_words_written;
  logic [NUM_REQ-1:0]    w_pick_onehot;
  logic [DATA_WIDTH-1:0] w_owner_data;
  logic                  w_in_grant, w_active, w_owner_valid, w_owner_last;
  logic                  w_xfer, w_release;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_valid        (bus.req_valid),
    .i_ptr          (r_rr_ptr),
    .o_grant_onehot (w_pick_onehot),
    .o_grant_idx    (w_pick_idx)
  );

  // A word presented during reset must not reach the buffer, hence the reset gate.
  assign w_in_grant    = (r_state == GRANT);
  assign w_active      = w_in_grant & ~i_reset;
  assign w_owner_valid = bus.req_valid[r_grant_id];
  assign w_owner_last  = bus.req_last[r_grant_id];
  assign w_owner_data  = bus.req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign w_xfer        = w_active & w_owner_valid & ~bus.buf_full;
  assign w_release     = w_in_grant &
                         (~w_owner_valid | (w_xfer & (w_owner_last | (r_beat_cnt == BEAT_MAX))));
  assign w_grant_inc   = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + IDX_W'(1);

  // Next-state: arbitrate in IDLE, count beats and release in GRANT.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_ptr_nxt   = r_rr_ptr;
    w_beat_nxt  = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (|w_pick_onehot) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_pick_idx;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_grant_inc;
          w_beat_nxt  = '0;
        end else if (w_xfer) begin
          w_beat_nxt = r_beat_cnt + BEAT_W'(1);
        end else begin
          w_beat_nxt = r_beat_cnt;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_ptr_nxt   = '0;
        w_beat_nxt  = '0;
      end
    endcase
  end

  // State and statistics registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= IDLE;
      r_grant_id      <= '0;
      r_rr_ptr        <= '0;
      r_beat_cnt      <= '0;
      r_words_written <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_nxt;
      r_rr_ptr   <= w_ptr_nxt;
      r_beat_cnt <= w_beat_nxt;
      if (w_xfer) begin
        r_words_written <= r_words_written + CNT_WIDTH'(1);
      end else begin
        r_words_written <= r_words_written;
      end
    end
  end

  // Ready and write strobe follow buf_full in the same cycle.
  always_comb begin
    bus.req_ready             = '0;
    bus.req_ready[r_grant_id] = w_active & ~bus.buf_full;
    bus.buf_write_enable      = w_xfer;
    bus.buf_write_data        = w_xfer ? w_owner_data : '0;
  end

  assign bus.grant_valid   = w_in_grant;
  assign bus.grant_id      = r_grant_id;
  assign bus.words_written = r_words_written;
endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Randomized bench for buffer_write_arbiter: producer queues drive the DUT, a reference
// model predicts each cycle into a scoreboard queue, and a monitor compares it.
module tb_buffer_write_arbiter;
  import snn_buf_pkg::*;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam int CW = 8;

  typedef struct packed {
    logic          gv;
    logic [1:0]    gid;
    logic [NR-1:0] rdy;
    logic          we;
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buffer_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  buffer_write_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Producer word stores: {last, data}
  logic [DW:0]  fifo_m [NR][64];
  int unsigned  hd [NR];
  int unsigned  tl [NR];
  logic [NR-1:0] acc;
  int  pause_pct, full_pct, last_pct;
  logic force_full, refill;

  exp_t expq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  int            m_owner = -1;
  int            m_ptr   = 0;
  int            m_beats = 0;
  logic [CW-1:0] m_cnt   = '0;
  logic          m_known = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic push_word(input int r, input logic [DW-1:0] d, input logic l);
    fifo_m[r][tl[r] % 64] = {l, d};
    tl[r]++;
  endtask

  task automatic step(input logic r);
    logic [NR-1:0]    v, l;
    logic [NR*DW-1:0] d;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) hd[i]++;
      if (refill && (tl[i] - hd[i]) < 4)
        push_word(i, $urandom(), int'($urandom_range(99)) < last_pct);
      if ((tl[i] != hd[i]) && (int'($urandom_range(99)) >= pause_pct)) begin
        v[i] = 1'b1;
        {l[i], d[i*DW +: DW]} = fifo_m[i][hd[i] % 64];
      end else begin
        v[i] = 1'b0;
        l[i] = 1'($urandom_range(1));
        d[i*DW +: DW] = $urandom();
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.buf_full  = force_full | (int'($urandom_range(99)) < full_pct);
    rst = r;
  endtask

  // One model evaluation per cycle, after inputs settle and before the closing edge.
  task automatic model_step();
    exp_t e;
    int   g;
    int   c;
    logic xfer;
    e     = '0;
    e.gv  = (m_owner >= 0);
    e.gid = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.cnt = m_cnt;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_beats = 0;
      m_cnt   = '0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NR; k++) begin
        c = (m_ptr + k) % NR;
        if (bus.req_valid[c] && m_owner < 0) m_owner = c;
      end
    end else begin
      g = m_owner;
      if (!bus.buf_full) e.rdy[g] = 1'b1;
      xfer = bus.req_valid[g] && !bus.buf_full;
      if (xfer) begin
        e.we   = 1'b1;
        e.data = bus.req_data[g*DW +: DW];
        m_cnt  = m_cnt + 1'b1;
        m_beats++;
      end
      if ((xfer && (bus.req_last[g] || m_beats == BL)) || !bus.req_valid[g]) begin
        m_owner = -1;
        m_ptr   = (g + 1) % NR;
        m_beats = 0;
      end
    end
    if (m_known) expq.push_back(e);
    m_known = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #3;
      model_step();
    end
  end

  // Monitor: record handshakes for the producers, and check the predicted cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("grant_valid",   64'(bus.grant_valid),      64'(e.gv));
        chk("grant_id",      64'(bus.grant_id),         64'(e.gid));
        chk("req_ready",     64'(bus.req_ready),        64'(e.rdy));
        chk("write_enable",  64'(bus.buf_write_enable), 64'(e.we));
        chk("write_data",    64'(bus.buf_write_data),   64'(e.data));
        chk("words_written", 64'(bus.words_written),    64'(e.cnt));
      end
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    acc = '0;
    pause_pct = 0; full_pct = 0; last_pct = 0;
    force_full = 1'b0; refill = 1'b0;
    rst = 1'b1;
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.buf_full = 1'b0;
    repeat (3) step(1'b1);

    // Single requester 1: A, B, C with last on C
    push_word(1, 32'hAAAA_0001, 1'b0);
    push_word(1, 32'hBBBB_0002, 1'b0);
    push_word(1, 32'hCCCC_0003, 1'b1);
    repeat (8) step(1'b0);

    // Requesters 0 and 2 streaming without last: forced rotation every BL words
    for (int k = 0; k < 16; k++) begin
      push_word(0, 32'h0000_1000 + k, 1'b0);
      push_word(2, 32'h2000_0000 + k, 1'b0);
    end
    repeat (45) step(1'b0);

    // Requester 0 with buffer full for 5 cycles mid-burst
    for (int k = 0; k < 8; k++) push_word(0, 32'h0F00_0000 + k, 1'b0);
    repeat (3) step(1'b0);
    force_full = 1'b1;
    repeat (5) step(1'b0);
    force_full = 1'b0;
    repeat (14) step(1'b0);

    // Requester 3 pauses after 2 words while requester 1 waits
    push_word(3, 32'h3333_0000, 1'b0);
    push_word(3, 32'h3333_0001, 1'b0);
    repeat (2) step(1'b0);
    for (int k = 0; k < 3; k++) push_word(1, 32'h1111_0000 + k, k == 2);
    repeat (12) step(1'b0);

    // Reset mid-burst after 2 of 4 words; requester 0 must win next
    for (int k = 0; k < 4; k++) push_word(2, 32'h2222_0000 + k, 1'b0);
    repeat (3) step(1'b0);
    push_word(0, 32'h0000_AA00, 1'b0);
    push_word(0, 32'h0000_AA01, 1'b1);
    step(1'b1);
    repeat (14) step(1'b0);

    // Random traffic: pauses, full stalls, random lasts, counter wraps many times
    pause_pct = 20; full_pct = 15; last_pct = 25; refill = 1'b1;
    repeat (1500) step(1'b0);
    pause_pct = 0; full_pct = 0; last_pct = 0;
    repeat (300) step(1'b0);
    refill = 1'b0;
    repeat (4) step(1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/buffer_write_arbiter.md
Name: buffer_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of one data buffer FIFO (32-bit, full/empty flags) between NUM_REQ producers, such as the DMA input loader and the layer-output writeback.
- Each producer uses a valid/ready handshake with a last marker.
- A grant is held for a burst of up to BURST_LEN words, then rotates.
- The arbiter never writes into a full buffer and never drops or duplicates a word.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, word width; matches buffer write_data
BURST_LEN, 4, maximum words per grant before forced rotation (1..16)
CNT_WIDTH, 16, width of the words_written statistics counter

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high; clears all state on the clock edge where it is high
req_valid  in  NUM_REQ  per-requester word-valid
req_last  in  NUM_REQ  per-requester marker: the current word ends the burst
req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
buf_full  in  1  buffer_full from the data buffer (combinational, same cycle)
buf_write_enable  out  1  buffer write strobe
buf_write_data  out  DATA_WIDTH  word to the buffer
grant_valid  out  1  a requester currently owns the port
grant_id  out  $clog2(NUM_REQ)  index of the owner; 0 when grant_valid=0
words_written  out  CNT_WIDTH  count of accepted words, wraps modulo 2^CNT_WIDTH

Behaviour:
- FSM states: IDLE, GRANT. State after reset: IDLE.
- Reset values: grant_valid=0, grant_id=0, rr_ptr=0, beat_cnt=0, words_written=0, req_ready=0, buf_write_enable=0, buf_write_data=0.
- IDLE:
  - If any req_valid is high, select the first requester at or after rr_ptr, searching upward and wrapping at NUM_REQ.
  - Register the selection as grant_id and go to GRANT next cycle.
  - No writes occur in IDLE.
- Latency: req_valid seen in cycle N (IDLE) gives grant_valid=1 in N+1; the first write can happen in N+1.
- GRANT, with g = grant_id:
  - req_ready[g] = ~buf_full (combinational). All other ready bits are 0.
  - A transfer occurs when req_valid[g] & req_ready[g].
  - On a transfer: buf_write_enable=1, buf_write_data=req_data[g], beat_cnt += 1, words_written += 1.
  - Otherwise: buf_write_enable=0 and buf_write_data=0.
- Grant release: return to IDLE next cycle when either of these holds:
  - a transfer occurs with req_last[g]=1 or beat_cnt==BURST_LEN-1; or
  - req_valid[g]=0 (the requester paused, which counts as the end of its burst).
- On release: rr_ptr = (g+1) mod NUM_REQ, beat_cnt=0, grant_valid=0, grant_id=0.
- There is always one bubble cycle (IDLE) between consecutive grants, including when the same requester wins again.
- buf_full while granted: the arbiter stalls, holding the grant with ready low. There is no timeout. buf_full has priority over valid.
- buf_full while IDLE: arbitration still proceeds; the new owner then stalls in GRANT.
- Single active requester: it is regranted after each bubble; the rotation still advances rr_ptr.
- Reset mid-burst: all state returns to reset values on that edge. A word presented in the same cycle as reset is not written.
- words_written wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- The data buffer gives write priority over read when both are asserted. Read scheduling is outside this block.

Decomposition:
- Shared package snn_buf_pkg:
  - typedef arb_state_t {IDLE, GRANT}
  - localparam DATA_WIDTH=32
  - function rr_select(valid, ptr), returning the round-robin winner index
- Sub-module rr_priority_picker: combinational. Inputs are the valid vector and the pointer; outputs are the one-hot winner and the index. It is reused by the planned read-side scheduler.

Test Plan:
- Single requester 1 sends 3 words A,B,C with last on C, buffer not full. Required: grant_valid rises the cycle after valid; writes A,B,C on 3 consecutive cycles; grant drops; rr_ptr=2; words_written=3.
- Requesters 0 and 2 both hold valid continuously with BURST_LEN=4 and no last. Required: grants alternate 0,2,0,2; exactly 4 writes per grant; exactly 1 bubble cycle between grants.
- Requester 0 is granted and buf_full is forced high for 5 cycles mid-burst. Required: req_ready[0]=0 and buf_write_enable=0 for those 5 cycles; grant is held; the burst resumes with no lost or duplicated word.
- Requester 3 drops valid after 2 words. Required: release the next cycle; waiting requester 1 is granted after the bubble.
- Reset asserted for 1 cycle mid-burst with 2 of 4 words written. Required: all outputs at reset values the next cycle; words_written=0; the next arbitration starts from requester 0.
- Preload words_written to 0xFFFF and perform 2 transfers. Required: counter reads 0x0001.
